kmeans_result_streamer: RTL and testbench

Hardware readout path for the k-means clusterer. After clustering completes, this block walks the point memory and returns every point's coordinates and assigned label as a valid/ready stream, one beat per point, in address order. It sits between the point memory's read port and the host/UART/DMA side. It is the hardware replacement for bench-side hierarchical readout of `x_mem`/`y_mem`/`z_mem`/`label_mem`.

---
 rtl/kmeans_pkg.sv | 13 +
 rtl/kmeans_stream_fifo2.sv | 32 +++
 rtl/kmeans_result_streamer.sv | 119 +++++++++++
 tb/tb_kmeans_result_streamer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared constants and FSM state type for the k-means clusterer readout path.
package kmeans_pkg;
  localparam int COORD_W  = 8;
  localparam int LABEL_W  = 2;
  localparam int N_POINTS = 12;
  localparam int OUT_W    = 3*COORD_W + LABEL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/kmeans_stream_fifo2.sv
// Two-entry FIFO with occupancy count; entry 0 is always the head.
module kmeans_stream_fifo2 #(
  parameter int W = kmeans_pkg::OUT_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] e0, e1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= 2'd0;
    else        count <= count + {1'b0, push} - {1'b0, pop};
  end

  // Payload carries no reset; the consumer qualifies it with count.
  always_ff @(posedge clk) begin
    if (pop) begin
      e0 <= (push && count == 2'd1) ? din : e1;
      if (push && count == 2'd2) e1 <= din;
    end else if (push) begin
      if (count == 2'd0) e0 <= din;
      else               e1 <= din;
    end
  end

  assign dout = e0;
endmodule

// File: rtl/kmeans_result_streamer.sv
// Walks the point memory after clustering and streams {x,y,z,label} beats.
// Define KMEANS_STREAM_CHECKSUM_EN to append an XOR checksum beat.
module kmeans_result_streamer
  import kmeans_pkg::*;
#(
  parameter int N_POINTS = kmeans_pkg::N_POINTS,
  parameter int COORD_W  = kmeans_pkg::COORD_W,
  parameter int LABEL_W  = kmeans_pkg::LABEL_W,
  parameter int ADDR_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [COORD_W-1:0]           mem_x,
  input  logic [COORD_W-1:0]           mem_y,
  input  logic [COORD_W-1:0]           mem_z,
  input  logic [LABEL_W-1:0]           mem_label,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3*COORD_W+LABEL_W-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);
  localparam int OW = 3*COORD_W + LABEL_W;
  localparam logic [ADDR_W:0] END_A = (ADDR_W+1)'(N_POINTS);

  state_t          state, state_nx;
  logic [ADDR_W:0] addr_p0;
  logic            rd_vld_p1;
  logic [1:0]      cnt;
  logic [2:0]      occ;
  logic            pop, push, push_last, start_acc;
  logic [OW-1:0]   mem_word_p1, push_data;
  logic [OW:0]     head;

  assign start_acc   = start && (state != RUN);
  assign out_valid   = (cnt != 2'd0);
  assign pop         = out_valid && out_ready;
  // Credit includes the beat leaving this cycle so a full-rate stream never starves.
  assign occ         = {1'b0, cnt} + {2'b0, rd_vld_p1} - {2'b0, pop};
  assign mem_rd_en   = (state == RUN) && (addr_p0 < END_A) && (occ < 3'd2);
  assign mem_addr    = addr_p0[ADDR_W-1:0];
  assign mem_word_p1 = {mem_x, mem_y, mem_z, mem_label};

  // Stage p0: read issue and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_p0   <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state     <= state_nx;
      rd_vld_p1 <= mem_rd_en;
      if (start_acc)      addr_p0 <= '0;
      else if (mem_rd_en) addr_p0 <= addr_p0 + (ADDR_W+1)'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (pop && head[0]) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p1: read return into the output buffer
`ifdef KMEANS_STREAM_CHECKSUM_EN
  logic [OW-1:0] csum;
  logic          cs_sent, cs_push;

  assign cs_push   = (state == RUN) && (addr_p0 == END_A) && !rd_vld_p1 &&
                     !cs_sent && (occ < 3'd2);
  assign push      = rd_vld_p1 || cs_push;
  assign push_data = rd_vld_p1 ? mem_word_p1 : csum;
  assign push_last = !rd_vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cs_sent <= 1'b0;
    else if (start_acc) cs_sent <= 1'b0;
    else if (cs_push)   cs_sent <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (start_acc)      csum <= '0;
    else if (rd_vld_p1) csum <= csum ^ mem_word_p1;
  end
`else
  localparam logic [ADDR_W:0] LAST_A = (ADDR_W+1)'(N_POINTS-1);
  logic rd_last_p1;

  assign push      = rd_vld_p1;
  assign push_data = mem_word_p1;
  assign push_last = rd_last_p1;

  always_ff @(posedge clk) rd_last_p1 <= (addr_p0 == LAST_A);
`endif

  kmeans_stream_fifo2 #(.W(OW+1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({push_data, push_last}),
    .pop   (pop),
    .dout  (head),
    .count (cnt)
  );

  // Stage p2: buffer head to the stream interface
  assign out_data = out_valid ? head[OW:1] : '0;
  assign out_last = out_valid && head[0];
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
endmodule

// File: tb/tb_kmeans_result_streamer.sv
// Bench for kmeans_result_streamer: table-driven point set, scoreboard on the output stream.
module tb_kmeans_result_streamer;
  localparam int NP = 12;
  localparam int OW = 26;
`ifdef KMEANS_STREAM_CHECKSUM_EN
  localparam int NB = NP + 1;
`else
  localparam int NB = NP;
`endif

  typedef struct packed {
    logic [7:0]    x;
    logic [7:0]    y;
    logic [7:0]    z;
    logic [1:0]    l;
    logic [OW-1:0] exp;
  } vec_t;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } beat_t;

  vec_t  tbl [NP];
  beat_t sb [$];

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic          mem_rd_en, out_valid, out_last, busy, done;
  logic [3:0]    mem_addr;
  logic [7:0]    mem_x, mem_y, mem_z;
  logic [1:0]    mem_label;
  logic [OW-1:0] out_data;

  logic          start_b, ready_b;
  logic          b_rd_en, b_valid, b_last, b_busy, b_done;
  logic [3:0]    b_addr;
  logic [7:0]    b_x, b_y, b_z;
  logic [1:0]    b_label;
  logic [OW-1:0] b_data;

  int total = 0;
  int bad = 0;
  int issued = 0;
  int accepted = 0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always #5 clk = ~clk;

  kmeans_result_streamer #(.N_POINTS(NP), .COORD_W(8), .LABEL_W(2), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_x(mem_x), .mem_y(mem_y), .mem_z(mem_z), .mem_label(mem_label),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  kmeans_result_streamer #(.N_POINTS(1), .COORD_W(8), .LABEL_W(2), .ADDR_W(4)) dut_one (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr),
    .mem_x(b_x), .mem_y(b_y), .mem_z(b_z), .mem_label(b_label),
    .out_valid(b_valid), .out_ready(ready_b), .out_data(b_data), .out_last(b_last),
    .busy(b_busy), .done(b_done)
  );

  // Point memory models, one cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en && mem_addr < 4'(NP)) begin
      mem_x     <= tbl[mem_addr].x;
      mem_y     <= tbl[mem_addr].y;
      mem_z     <= tbl[mem_addr].z;
      mem_label <= tbl[mem_addr].l;
    end
    if (b_rd_en && b_addr == 4'd0) begin
      b_x     <= tbl[0].x;
      b_y     <= tbl[0].y;
      b_z     <= tbl[0].z;
      b_label <= tbl[0].l;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Stream monitor: order, content, stall stability and read credit
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (mem_rd_en) begin
        chk("rd_addr", 32'(mem_addr), issued);
        chk("rd_range", 32'(mem_addr < 4'(NP)), 32'd1);
        issued++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got=%0h want=none", out_data);
        end else begin
          e = sb.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.d));
          chk("beat_last", 32'(out_last), 32'(e.l));
        end
        accepted++;
      end
      if (mem_rd_en) chk("credit", 32'((issued - accepted) <= 2), 32'd1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic arm();
    logic [OW-1:0] cs;
    cs = '0;
    sb.delete();
    for (int i = 0; i < NP; i++) begin
      sb.push_back({tbl[i].exp, 1'((NB == NP) && (i == NP-1))});
      cs = cs ^ tbl[i].exp;
    end
`ifdef KMEANS_STREAM_CHECKSUM_EN
    sb.push_back({cs, 1'b1});
`endif
    issued = 0;
    accepted = 0;
  endtask

  task automatic start_seq();
    arm();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_ready(input int mode, input int start_at);
    int ph;
    int cyc;
    bit pulsed;
    ph = 0;
    cyc = 0;
    pulsed = 1'b0;
    while (!done && cyc < 400) begin
      start = 1'b0;
      if (!pulsed && accepted == start_at) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      case (mode)
        1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      ph++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("stream_done", 32'(done), 32'd1);
  endtask

  task automatic end_checks();
    chk("sb_empty", sb.size(), 32'd0);
    chk("beat_count", accepted, NB);
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    start_b = 1'b0;
    ready_b = 1'b1;

    for (int i = 0; i < NP; i++) begin
      tbl[i].x = (i == NP-1) ? 8'd91 : 8'(10 + 7*i);
      tbl[i].y = (i == NP-1) ? 8'd21 : 8'(10 + 13*i);
      tbl[i].z = (i == NP-1) ? 8'd72 : 8'(10 + 5*i*i);
      tbl[i].l = 2'(i % 4);
      tbl[i].exp = {tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].l};
    end

    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rd_en", 32'(mem_rd_en), 32'd0);

    // Full-rate readout: two-cycle latency, then back-to-back beats
    out_ready = 1'b1;
    arm();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_rd_en", 32'(mem_rd_en), 32'd1);
    chk("lat_addr0", 32'(mem_addr), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_valid_e0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_e1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_e2", 32'(out_valid), 32'd1);
    for (int k = 1; k < NB; k++) begin
      @(posedge clk); #1;
      chk("consecutive", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    chk("full_done", 32'(done), 32'd1);
    chk("full_valid_off", 32'(out_valid), 32'd0);
    end_checks();

    // Backpressure 1,0,0,1; restart from DONE
    start_seq();
    run_ready(1, -1);
    end_checks();

    // start at beat 5 must be ignored
    start_seq();
    run_ready(0, 5);
    end_checks();

    // start coincident with the final handshake must be ignored
    start_seq();
    run_ready(0, NB-1);
    @(posedge clk); #1;
    chk("fin_start_done", 32'(done), 32'd1);
    chk("fin_start_busy", 32'(busy), 32'd0);
    chk("fin_start_rd_en", 32'(mem_rd_en), 32'd0);

    // Reset mid-readout at beat 6, then a clean readout
    start_seq();
    out_ready = 1'b1;
    cyc = 0;
    while (accepted < 6 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_reach_beat6", accepted, 32'd6);
    rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_seq();
    run_ready(0, -1);
    end_checks();

    // Random backpressure
    start_seq();
    run_ready(2, -1);
    end_checks();

    // Single-point instance
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 0;
    while (!b_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("one_valid", 32'(b_valid), 32'd1);
    chk("one_data", 32'(b_data), 32'(tbl[0].exp));
`ifdef KMEANS_STREAM_CHECKSUM_EN
    chk("one_last", 32'(b_last), 32'd0);
    @(posedge clk); #1;
    chk("one_cs_valid", 32'(b_valid), 32'd1);
    chk("one_cs_data", 32'(b_data), 32'(tbl[0].exp));
    chk("one_cs_last", 32'(b_last), 32'd1);
`else
    chk("one_last", 32'(b_last), 32'd1);
`endif
    @(posedge clk); #1;
    chk("one_done", 32'(b_done), 32'd1);
    chk("one_busy", 32'(b_busy), 32'd0);
    chk("one_valid_off", 32'(b_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
